rect_grid_memory: RTL and testbench

- Storage end of the rect write/read interface: holds the GRID_W x GRID_H cell-code map that the snake game controller writes with {x,y,func} words and probes with {x,y} reads.
- Also serves a registered pixel-side read port for the VGA renderer.
- Contains a clear/initialise sweep engine that fills the map (NULL interior, optional ROCK border) after reset or on request.

---
 rtl/rect_grid_memory_if.sv | 37 +++
 rtl/rect_grid_memory.sv | 162 ++++++++++++++++
 tb/tb_rect_grid_memory.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/rect_grid_memory_if.sv
// rect_grid_memory_if
// Bundles every non-clock, non-reset signal of the grid memory.
//   master : snake controller + VGA renderer side (drives writes, probes, pixel coords)
//   slave  : rect_grid_memory (returns cell codes, sweep status, pixel cell)
// Signals:
//   rect_write     {x[35:20], y[19:4], func[3:0]} continuous write word
//   rect_read_addr {x[31:16], y[15:0]} controller probe address
//   rect_read_data combinational cell code at rect_read_addr
//   clr            one-cycle request to restart the clear sweep
//   busy           clear sweep in progress
//   clear_done     one-cycle pulse when a sweep finishes
//   disp_hcount    renderer pixel x
//   disp_vcount    renderer pixel y
//   disp_cell      registered cell code under the pixel
//   disp_valid     disp_cell belongs to a visible in-grid pixel
interface rect_grid_memory_if;
   logic [35:0] rect_write;
   logic [31:0] rect_read_addr;
   logic [3:0]  rect_read_data;
   logic        clr;
   logic        busy;
   logic        clear_done;
   logic [10:0] disp_hcount;
   logic [10:0] disp_vcount;
   logic [3:0]  disp_cell;
   logic        disp_valid;

   modport master (
      output rect_write, rect_read_addr, clr, disp_hcount, disp_vcount,
      input  rect_read_data, busy, clear_done, disp_cell, disp_valid
   );

   modport slave (
      input  rect_write, rect_read_addr, clr, disp_hcount, disp_vcount,
      output rect_read_data, busy, clear_done, disp_cell, disp_valid
   );
endinterface

// File: rtl/rect_grid_memory.sv
// rect_grid_memory
// Cell-code map for the snake game. The controller writes {x,y,func} words
// continuously and probes single cells; the VGA renderer reads the cell under
// its current pixel through a registered port. A sweep engine fills the map
// (NULL interior, optional ROCK border) after reset or on a clr request.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset, restarts the sweep
//   bus  rect_grid_memory_if.slave (write word, probe port, clr/busy/clear_done,
//        display coordinates and registered display cell)
module rect_grid_memory #(
   parameter int GRID_W       = 32,
   parameter int GRID_H       = 24,
   parameter int CELL_SHIFT   = 5,
   parameter int BORDER_ROCKS = 1
) (
   input logic               clk,
   input logic               rst,
   rect_grid_memory_if.slave bus
);

   localparam int          CELLS     = GRID_W * GRID_H;
   localparam int          IDX_W     = $clog2(CELLS);
   localparam logic [15:0] GRID_W16  = 16'(GRID_W);
   localparam logic [15:0] GRID_H16  = 16'(GRID_H);
   localparam logic [10:0] GRID_W11  = 11'(GRID_W);
   localparam logic [10:0] GRID_H11  = 11'(GRID_H);
   localparam logic [3:0]  NULL_CODE = 4'h0;
   localparam logic [3:0]  ROCK_CODE = 4'h2;

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   state_t      state_q, state_d;
   logic [15:0] sx_q, sx_d;
   logic [15:0] sy_q, sy_d;
   logic        clear_done_q, clear_done_d;
   logic [3:0]  disp_cell_q, disp_cell_d;
   logic        disp_valid_q, disp_valid_d;
   logic [3:0]  mem_q [CELLS];

   logic             wr_en;
   logic [IDX_W-1:0] wr_idx;
   logic [3:0]       wr_data;

   logic [15:0] wx, wy, rx, ry;
   logic [3:0]  wfunc;
   logic [10:0] cx, cy;
   logic        w_in_range, r_in_range, sweep_last, sweep_border;

   // Callers only use the result for in-range coordinates, so the truncation
   // to IDX_W bits never aliases two valid cells.
   function automatic logic [IDX_W-1:0] cell_idx(input logic [15:0] x, input logic [15:0] y);
      logic [31:0] lin;
      lin = {16'd0, y} * GRID_W + {16'd0, x};
      return lin[IDX_W-1:0];
   endfunction

   assign wx    = bus.rect_write[35:20];
   assign wy    = bus.rect_write[19:4];
   assign wfunc = bus.rect_write[3:0];
   assign rx    = bus.rect_read_addr[31:16];
   assign ry    = bus.rect_read_addr[15:0];
   assign cx    = bus.disp_hcount >> CELL_SHIFT;
   assign cy    = bus.disp_vcount >> CELL_SHIFT;

   // Full 16-bit compares: any upper bit set puts the access off the grid.
   assign w_in_range = (wx < GRID_W16) && (wy < GRID_H16);
   assign r_in_range = (rx < GRID_W16) && (ry < GRID_H16);

   assign sweep_last   = (sx_q == GRID_W16 - 16'd1) && (sy_q == GRID_H16 - 16'd1);
   assign sweep_border = (sx_q == 16'd0) || (sx_q == GRID_W16 - 16'd1) ||
                         (sy_q == 16'd0) || (sy_q == GRID_H16 - 16'd1);

   // Sweep sequencing and the single memory write port. The sweep owns the
   // write port while clearing, so controller writes are simply dropped then.
   always_comb begin
      state_d      = state_q;
      sx_d         = sx_q;
      sy_d         = sy_q;
      clear_done_d = 1'b0;
      wr_en        = 1'b0;
      wr_idx       = cell_idx(wx, wy);
      wr_data      = wfunc;
      case (state_q)
         ST_CLEAR: begin
            wr_en   = 1'b1;
            wr_idx  = cell_idx(sx_q, sy_q);
            wr_data = ((BORDER_ROCKS != 0) && sweep_border) ? ROCK_CODE : NULL_CODE;
            if (sweep_last) begin
               state_d      = ST_RUN;
               clear_done_d = 1'b1;
               sx_d         = 16'd0;
               sy_d         = 16'd0;
            end else if (sx_q == GRID_W16 - 16'd1) begin
               sx_d = 16'd0;
               sy_d = sy_q + 16'd1;
            end else begin
               sx_d = sx_q + 16'd1;
            end
         end
         ST_RUN: begin
            wr_en = w_in_range;
         end
         default: begin
            state_d = ST_CLEAR;
         end
      endcase
      if (bus.clr) begin
         state_d      = ST_CLEAR;
         sx_d         = 16'd0;
         sy_d         = 16'd0;
         clear_done_d = 1'b0;
      end
      if (rst) begin
         wr_en = 1'b0;
      end
   end

   // Renderer lookup, registered below; blanked while the sweep runs.
   always_comb begin
      disp_valid_d = (cx < GRID_W11) && (cy < GRID_H11) && (state_q == ST_RUN);
      disp_cell_d  = NULL_CODE;
      if (disp_valid_d) begin
         disp_cell_d = mem_q[cell_idx({5'd0, cx}, {5'd0, cy})];
      end
   end

   // Control and display registers; reset restarts the sweep from cell 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_CLEAR;
         sx_q         <= 16'd0;
         sy_q         <= 16'd0;
         clear_done_q <= 1'b0;
         disp_cell_q  <= NULL_CODE;
         disp_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sx_q         <= sx_d;
         sy_q         <= sy_d;
         clear_done_q <= clear_done_d;
         disp_cell_q  <= disp_cell_d;
         disp_valid_q <= disp_valid_d;
      end
   end

   // Cell storage: one write per cycle, reads see the pre-write contents.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_idx] <= wr_data;
      end
   end

   assign bus.rect_read_data = !r_in_range ? ROCK_CODE :
                               (state_q == ST_CLEAR) ? NULL_CODE :
                               mem_q[cell_idx(rx, ry)];
   assign bus.busy       = (state_q == ST_CLEAR);
   assign bus.clear_done = clear_done_q;
   assign bus.disp_cell  = disp_cell_q;
   assign bus.disp_valid = disp_valid_q;

endmodule

// File: tb/tb_rect_grid_memory.sv
// tb_rect_grid_memory
// Drives a bordered and a border-less grid memory with the same inputs and
// compares probe reads, display output and sweep timing against hand-derived
// values.
module tb_rect_grid_memory;

   localparam int          SWEEP_CYCLES = 768;
   localparam logic [35:0] IDLE_WR      = {16'hFFFF, 16'hFFFF, 4'h0};

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total  = 0;
   int   passed = 0;

   rect_grid_memory_if ifc ();
   rect_grid_memory_if ifc_nb ();

   // The border-less instance just mirrors the main stimulus.
   assign ifc_nb.rect_write     = ifc.rect_write;
   assign ifc_nb.rect_read_addr = ifc.rect_read_addr;
   assign ifc_nb.clr            = ifc.clr;
   assign ifc_nb.disp_hcount    = ifc.disp_hcount;
   assign ifc_nb.disp_vcount    = ifc.disp_vcount;

   rect_grid_memory #(.GRID_W(32), .GRID_H(24), .CELL_SHIFT(5), .BORDER_ROCKS(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   rect_grid_memory #(.GRID_W(32), .GRID_H(24), .CELL_SHIFT(5), .BORDER_ROCKS(0)) dut_nb (
      .clk (clk),
      .rst (rst),
      .bus (ifc_nb.slave)
   );

   // 100 MHz-style free-running clock.
   always #5 clk = ~clk;

   typedef struct {
      logic [35:0] wrWord;
      logic [31:0] rdAddr;
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic [3:0]  expRead;
      logic [3:0]  expCell;
      logic        expValid;
   } vec_t;

   vec_t vecs[16];

   function automatic logic [35:0] wr(input logic [15:0] x, input logic [15:0] y, input logic [3:0] f);
      return {x, y, f};
   endfunction

   function automatic logic [31:0] ad(input logic [15:0] x, input logic [15:0] y);
      return {x, y};
   endfunction

   // One comparison: bumps the counters and reports a mismatch.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end else begin
         passed++;
      end
   endtask

   // Probe one cell on either instance through the combinational read port.
   task automatic probe(input logic [15:0] x, input logic [15:0] y, input logic [3:0] expected,
                        input string name, input bit useNb);
      ifc.rect_read_addr = {x, y};
      #1;
      checkOutput(name, useNb ? 32'(ifc_nb.rect_read_data) : 32'(ifc.rect_read_data), 32'(expected));
   endtask

   // One table row: read checked in the same cycle, display one edge later.
   task automatic applyStimulus(input vec_t v, input int i);
      ifc.rect_write     = v.wrWord;
      ifc.rect_read_addr = v.rdAddr;
      ifc.disp_hcount    = v.hcount;
      ifc.disp_vcount    = v.vcount;
      #1;
      checkOutput($sformatf("vec%0d_read", i), 32'(ifc.rect_read_data), 32'(v.expRead));
      @(negedge clk);
      checkOutput($sformatf("vec%0d_disp_cell", i), 32'(ifc.disp_cell), 32'(v.expCell));
      checkOutput($sformatf("vec%0d_disp_valid", i), 32'(ifc.disp_valid), 32'(v.expValid));
   endtask

   // Called on the negedge where the sweep starts; counts busy cycles and
   // clear_done pulses, optionally resetting mid-sweep or writing meanwhile.
   task automatic runSweep(input int rstAt, input bit injectWrite, input string tag);
      int cnt = 0;
      int pulses = 0;
      int guard = 0;
      bit restarted = 1'b0;
      while (ifc.busy === 1'b1 && guard < 3000) begin
         guard++;
         cnt++;
         if (rstAt > 0 && !restarted && cnt == rstAt) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            restarted = 1'b1;
            cnt = 1;
         end
         if (injectWrite) begin
            ifc.rect_write = (cnt >= 500 && cnt < 510) ? wr(16'd6, 16'd6, 4'h4) : IDLE_WR;
         end
         if (cnt == 400) begin
            probe(16'd0, 16'd5, 4'h0, {tag, "_busy_inrange_null"}, 1'b0);
            probe(16'd40, 16'd0, 4'h2, {tag, "_busy_oor_rock"}, 1'b0);
         end
         if (ifc.clear_done === 1'b1) pulses++;
         @(negedge clk);
      end
      if (ifc.clear_done === 1'b1) pulses++;
      checkOutput({tag, "_busy_cycles"}, 32'(cnt), 32'(SWEEP_CYCLES));
      checkOutput({tag, "_done_pulses"}, 32'(pulses), 32'd1);
      ifc.rect_write = IDLE_WR;
      @(negedge clk);
      checkOutput({tag, "_done_single"}, 32'(ifc.clear_done), 32'd0);
   endtask

   // Main sequence: reset sweep, table vectors, clr sweep, reset mid-sweep.
   initial begin
      vecs[0]  = '{wr(16'd15, 16'd15, 4'h1), ad(16'd15, 16'd15), 11'd0,    11'd0,    4'h0, 4'h2, 1'b1};
      vecs[1]  = '{IDLE_WR,                  ad(16'd15, 16'd15), 11'd485,  11'd485,  4'h1, 4'h1, 1'b1};
      vecs[2]  = '{wr(16'd15, 16'd15, 4'h0), ad(16'd15, 16'd15), 11'd485,  11'd485,  4'h1, 4'h1, 1'b1};
      vecs[3]  = '{IDLE_WR,                  ad(16'd15, 16'd15), 11'd485,  11'd485,  4'h0, 4'h0, 1'b1};
      vecs[4]  = '{wr(16'd32, 16'd3, 4'h4),  ad(16'd0, 16'd3),   11'd2047, 11'd2047, 4'h2, 4'h0, 1'b0};
      vecs[5]  = '{IDLE_WR,                  ad(16'd0, 16'd4),   11'd5,    11'd133,  4'h2, 4'h2, 1'b1};
      vecs[6]  = '{wr(16'h0021, 16'd5, 4'h4), ad(16'd40, 16'd0), 11'd2047, 11'd2047, 4'h2, 4'h0, 1'b0};
      vecs[7]  = '{IDLE_WR,                  ad(16'd1, 16'd5),   11'd33,   11'd165,  4'h0, 4'h0, 1'b1};
      vecs[8]  = '{IDLE_WR,                  ad(16'hFFFF, 16'd2), 11'd2047, 11'd2047, 4'h2, 4'h0, 1'b0};
      vecs[9]  = '{wr(16'd5, 16'h0101, 4'h4), ad(16'd5, 16'd1),  11'd2047, 11'd2047, 4'h0, 4'h0, 1'b0};
      vecs[10] = '{IDLE_WR,                  ad(16'd5, 16'd1),   11'd165,  11'd37,   4'h0, 4'h0, 1'b1};
      vecs[11] = '{wr(16'd10, 16'd7, 4'h4),  ad(16'd5, 16'd5),   11'd2047, 11'd2047, 4'h0, 4'h0, 1'b0};
      vecs[12] = '{IDLE_WR,                  ad(16'd10, 16'd7),  11'd330,  11'd230,  4'h4, 4'h4, 1'b1};
      vecs[13] = '{IDLE_WR,                  ad(16'd31, 16'd23), 11'd1030, 11'd230,  4'h2, 4'h0, 1'b0};
      vecs[14] = '{IDLE_WR,                  ad(16'd0, 16'd23),  11'd330,  11'd768,  4'h2, 4'h0, 1'b0};
      vecs[15] = '{IDLE_WR,                  ad(16'd16, 16'd0),  11'd1023, 11'd767,  4'h2, 4'h2, 1'b1};

      ifc.rect_write     = IDLE_WR;
      ifc.rect_read_addr = 32'd0;
      ifc.clr            = 1'b0;
      ifc.disp_hcount    = 11'd2047;
      ifc.disp_vcount    = 11'd2047;
      rst                = 1'b1;

      @(negedge clk);
      checkOutput("reset_busy", 32'(ifc.busy), 32'd1);
      checkOutput("reset_clear_done", 32'(ifc.clear_done), 32'd0);
      checkOutput("reset_disp_cell", 32'(ifc.disp_cell), 32'd0);
      checkOutput("reset_disp_valid", 32'(ifc.disp_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      runSweep(0, 1'b0, "init");

      probe(16'd0, 16'd5, 4'h2, "init_border_0_5", 1'b0);
      probe(16'd5, 16'd5, 4'h0, "init_interior_5_5", 1'b0);
      probe(16'd31, 16'd23, 4'h2, "init_corner_31_23", 1'b0);
      probe(16'd0, 16'd5, 4'h0, "noborder_0_5", 1'b1);
      probe(16'd31, 16'd23, 4'h0, "noborder_31_23", 1'b1);

      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(vecs[i], i);
      end

      ifc.rect_write = wr(16'd4, 16'd4, 4'h1);
      @(negedge clk);
      ifc.rect_write = IDLE_WR;
      probe(16'd4, 16'd4, 4'h1, "clr_pre_snake", 1'b0);
      @(negedge clk);
      ifc.clr = 1'b1;
      @(negedge clk);
      ifc.clr = 1'b0;
      runSweep(0, 1'b1, "clr");
      probe(16'd4, 16'd4, 4'h0, "clr_snake_cleared", 1'b0);
      probe(16'd6, 16'd6, 4'h0, "clr_write_dropped", 1'b0);
      probe(16'd10, 16'd7, 4'h0, "clr_snack_cleared", 1'b0);
      probe(16'd0, 16'd5, 4'h2, "clr_border_restored", 1'b0);

      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      runSweep(300, 1'b0, "rstmid");
      probe(16'd0, 16'd5, 4'h2, "rstmid_border", 1'b0);
      probe(16'd5, 16'd5, 4'h0, "rstmid_interior", 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
